// File: rtl/e_clkgen_if.sv
//------------------------------------------------------------------------------
// e_clkgen_if
//   Bus bundle between the E/Q clock generator and its user.
//   Revision: 1.0
//
//   Signals
//     ENABLE       run request (driven by master)
//     MRDY         memory ready, low requests an E stretch (driven by master)
//     EX, QX       E and Q clocks for the 6809E (driven by slave)
//     PHASE[1:0]   current phase number 0..3 (driven by slave)
//     CYCLE_START  one-clock strobe on entry to phase 1 (driven by slave)
//     STRETCHING   high while E is held by MRDY (driven by slave)
//     STRETCH_TO   one-clock strobe when the stretch limit ends a cycle
//
//   Modports
//     master  system side: drives ENABLE/MRDY, observes the clock outputs
//     slave   the clock generator itself
//------------------------------------------------------------------------------
`default_nettype none

interface e_clkgen_if;
    logic       ENABLE;
    logic       MRDY;
    logic       EX;
    logic       QX;
    logic [1:0] PHASE;
    logic       CYCLE_START;
    logic       STRETCHING;
    logic       STRETCH_TO;

    modport master (
        output ENABLE,
        output MRDY,
        input  EX,
        input  QX,
        input  PHASE,
        input  CYCLE_START,
        input  STRETCHING,
        input  STRETCH_TO
    );

    modport slave (
        input  ENABLE,
        input  MRDY,
        output EX,
        output QX,
        output PHASE,
        output CYCLE_START,
        output STRETCHING,
        output STRETCH_TO
    );
endinterface

`default_nettype wire

// File: rtl/e_clkgen.sv
//------------------------------------------------------------------------------
// e_clkgen
//   Quadrature E/Q clock generator for the 6809E, derived from CLKX4.
//   One phase per CLKX4 cycle (P0..P3). The E-high phase (P3) can be
//   stretched by MRDY low, up to MAX_STRETCH extra CLKX4 cycles per bus
//   cycle; a stretch ended by the limit raises STRETCH_TO for one cycle.
//   Revision: 1.0
//
//   Ports
//     CLKX4   in   master clock, all state changes on its rising edge
//     nRESET  in   asynchronous active-low reset
//     bus     slave modport of e_clkgen_if (ENABLE, MRDY in; EX, QX,
//             PHASE, CYCLE_START, STRETCHING, STRETCH_TO out)
//
//   Parameters
//     MAX_STRETCH  maximum extra E-high CLKX4 cycles per bus cycle (1..15)
//     CNT_W        stretch counter width, must hold MAX_STRETCH
//
//   Build option
//     CLKGEN_MRDY_SYNC_EN  when defined, MRDY passes through a 2-flop
//                          synchroniser (reset to 1) before use in P3;
//                          otherwise the raw pin is used at the edge.
//------------------------------------------------------------------------------
`default_nettype none

module e_clkgen #(
    parameter int MAX_STRETCH = 8,
    parameter int CNT_W       = 4
) (
    input  wire logic   CLKX4,
    input  wire logic   nRESET,
    e_clkgen_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_MAX_STRETCH = CNT_W'(MAX_STRETCH);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_e;

    phase_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_q, ex_d;
    logic             qx_q, qx_d;
    logic             cs_q, cs_d;
    logic             str_q, str_d;
    logic             to_q, to_d;
    logic             mrdy_eff;

`ifdef CLKGEN_MRDY_SYNC_EN
    // Two-stage synchroniser; reset high so no stretch is requested
    // before the first real samples arrive.
    logic mrdy_s1_q;
    logic mrdy_s2_q;

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            mrdy_s1_q <= 1'b1;
            mrdy_s2_q <= 1'b1;
        end else begin
            mrdy_s1_q <= bus.MRDY;
            mrdy_s2_q <= mrdy_s1_q;
        end
    end

    assign mrdy_eff = mrdy_s2_q;
`else
    assign mrdy_eff = bus.MRDY;
`endif

    // State and registered outputs
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= P0;
            cnt_q   <= '0;
            ex_q    <= 1'b0;
            qx_q    <= 1'b0;
            cs_q    <= 1'b0;
            str_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            qx_q    <= qx_d;
            cs_q    <= cs_d;
            str_q   <= str_d;
            to_q    <= to_d;
        end
    end

    // Next state. Every path into P0 clears the counter and the
    // stretching flag, so they are already clear while PHASE reads 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        str_d   = str_q;
        to_d    = 1'b0;

        case (state_q)
            P0: begin
                cnt_d = '0;
                str_d = 1'b0;
                if (bus.ENABLE) begin
                    state_d = P1;
                end
            end
            P1: begin
                state_d = P2;
            end
            P2: begin
                state_d = P3;
            end
            P3: begin
                if (mrdy_eff) begin
                    state_d = P0;
                    cnt_d   = '0;
                    str_d   = 1'b0;
                end else if (cnt_q < c_MAX_STRETCH) begin
                    cnt_d   = cnt_q + c_CNT_ONE;
                    str_d   = 1'b1;
                end else begin
                    // Limit reached: leave P3 regardless of MRDY.
                    state_d = P0;
                    cnt_d   = '0;
                    str_d   = 1'b0;
                    to_d    = 1'b1;
                end
            end
            default: begin
                state_d = P0;
                cnt_d   = '0;
                str_d   = 1'b0;
            end
        endcase
    end

    // Clock outputs are decoded from the next state and registered, so
    // they change together with PHASE and never glitch from inputs.
    always_comb begin
        ex_d = (state_d == P2) || (state_d == P3);
        qx_d = (state_d == P1) || (state_d == P2);
        cs_d = (state_d == P1);
    end

    assign bus.EX          = ex_q;
    assign bus.QX          = qx_q;
    assign bus.PHASE       = state_q;
    assign bus.CYCLE_START = cs_q;
    assign bus.STRETCHING  = str_q;
    assign bus.STRETCH_TO  = to_q;

endmodule

`default_nettype wire

// File: tb/tb_e_clkgen.sv
//------------------------------------------------------------------------------
// tb_e_clkgen
//   Directed testbench for e_clkgen. Each step drives ENABLE/MRDY, queues
//   the outputs expected after the next CLKX4 edge and compares them once
//   the edge has passed.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_e_clkgen;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [6:0] exp_q[$];

    e_clkgen_if bus ();

    e_clkgen #(
        .MAX_STRETCH (8),
        .CNT_W       (4)
    ) dut (
        .CLKX4  (clk),
        .nRESET (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] obs();
        return {bus.EX, bus.QX, bus.PHASE, bus.CYCLE_START, bus.STRETCHING, bus.STRETCH_TO};
    endfunction

    task automatic check(input logic [6:0] got, input logic [6:0] want, input string tag);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s (check %0d): observed {EX,QX,PHASE,CS,STR,TO}=%b expected %b",
                   tag, n_checks, got, want);
        end
    endtask

    // Drive inputs for the coming edge, queue the expected outputs derived
    // from the expected phase, then compare after the edge.
    task automatic tick(input logic en, input logic mr, input logic [1:0] ph,
                        input logic st, input logic to, input string tag);
        logic       e_ex;
        logic       e_qx;
        logic       e_cs;
        logic [6:0] want;
        bus.ENABLE = en;
        bus.MRDY   = mr;
        e_ex = (ph == 2'd2) || (ph == 2'd3);
        e_qx = (ph == 2'd1) || (ph == 2'd2);
        e_cs = (ph == 2'd1);
        exp_q.push_back({e_ex, e_qx, ph, e_cs, st, to});
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(obs(), want, tag);
    endtask

    task automatic nominal_cycle(input string tag);
        tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, tag);
        tick(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, tag);
        tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, tag);
        tick(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, tag);
    endtask

    // MRDY held low for a whole cycle: 8 hold cycles then a forced exit.
    task automatic limit_cycle(input string tag);
        tick(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, tag);
        tick(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, tag);
        tick(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, tag);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, tag);
        end
        tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        bus.ENABLE = 1'b1;
        bus.MRDY   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check(obs(), 7'b0, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Free running after reset: 00,01,11,10 pattern
        nominal_cycle("nominal");
        nominal_cycle("nominal_repeat");

`ifndef CLKGEN_MRDY_SYNC_EN
        // MRDY low for three P3 edges: E high 5 clocks, STRETCHING 3 clocks
        tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "stretch3");
        tick(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, "stretch3");
        tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "stretch3");
        tick(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, "stretch3");
        tick(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, "stretch3");
        tick(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, "stretch3");
        tick(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, "stretch3_end");
        nominal_cycle("after_stretch3");

        // Low pulse on MRDY during P1/P2 only: ignored
        tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "mrdy_early");
        tick(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, "mrdy_early");
        tick(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, "mrdy_early");
        tick(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, "mrdy_early");

        // MRDY permanently low: limit reached each cycle, 12-clock period
        limit_cycle("limit1");
        limit_cycle("limit2");
        nominal_cycle("after_limit");

        // ENABLE dropped in P2: cycle completes, clock parks in P0
        tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "park");
        tick(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, "park");
        tick(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, "park");
        tick(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, "park");
        tick(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, "parked");
        tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "parked_mrdy_low");
        tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "parked_mrdy_low");
        tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "reenable");
        tick(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, "reenable");
        tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "reenable");
        tick(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, "reenable");

        // ENABLE low together with MRDY low in P3: stretch completes, then park
        tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "en_mrdy");
        tick(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, "en_mrdy");
        tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "en_mrdy");
        tick(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, "en_mrdy");
        tick(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, "en_mrdy");
        tick(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, "en_mrdy_park");
        tick(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, "en_mrdy_park");
        nominal_cycle("en_mrdy_resume");

        // Asynchronous reset in the second stretch cycle
        tick(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, "rst_mid");
        tick(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, "rst_mid");
        tick(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, "rst_mid");
        tick(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, "rst_mid");
        tick(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, "rst_mid");
        #2;
        rst_n = 1'b0;
        #1;
        check(obs(), 7'b0, "async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Full 8-cycle stretch available again after reset
        limit_cycle("post_reset_limit");
        nominal_cycle("post_reset_nominal");
`else
        // Synchronised MRDY: low only from the P2 edge is too late
        tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "sync_late");
        tick(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, "sync_late");
        tick(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, "sync_late");
        tick(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, "sync_late");
        nominal_cycle("sync_late_next");

        // Low sampled at the P2-entry edge (asserted at the P1 edge): stretch
        tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "sync_early");
        tick(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, "sync_early");
        tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "sync_early");
        tick(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, "sync_early");
        tick(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, "sync_early");
        nominal_cycle("sync_early_next");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
